// File: rtl/note_lane_gen.sv
// note_lane_gen: beat-timed pseudo-random lane sequencer for the game datapath.
// Issues one 2-bit lane per beat (BEAT_DIV clocks), NOTES notes per song,
// with pause support and a filter that forbids three identical lanes in a row.
module note_lane_gen #(
  parameter int unsigned BEAT_DIV = 25_000_000,
  parameter int unsigned NOTES    = 64,
  parameter logic [7:0]  SEED     = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  output logic [1:0] lane,
  output logic       note_valid,
  output logic       busy,
  output logic       done,
  output logic [6:0] note_cnt
);

  localparam int unsigned       BEAT_W    = $clog2(BEAT_DIV);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_DIV - 1);
  localparam logic [6:0]        LAST_NOTE = 7'(NOTES - 1);
  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [7:0]        SEED_EFF  = (SEED == 8'h00) ? 8'h01 : SEED;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [7:0]        lfsr_q, lfsr_d;
  logic [1:0]        lane_q, lane_d;
  logic [1:0]        hist0_q, hist0_d;   // most recently issued lane
  logic [1:0]        hist1_q, hist1_d;   // lane issued before that one
  logic              note_valid_q, note_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [6:0]        note_cnt_q, note_cnt_d;

  logic       lfsr_fb;
  logic [7:0] lfsr_step;
  logic [1:0] cand;
  logic       repeat_hit;
  logic [1:0] issue_lane;
  logic       beat_end;

  // Next LFSR state and the lane that would be issued on the coming beat
  always_comb begin
    lfsr_fb    = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    lfsr_step  = {lfsr_q[6:0], lfsr_fb};
    cand       = lfsr_step[1:0];
    // History only counts once two notes of this song have been issued,
    // so the tail of the previous song never bends the new one.
    repeat_hit = (note_cnt_q >= 7'd2) && (cand == hist0_q) && (cand == hist1_q);
    issue_lane = repeat_hit ? (cand + 2'd1) : cand;
    beat_end   = (beat_cnt_q == BEAT_LAST);
  end

  // Next-state logic: song control, beat timing and note issue
  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    lfsr_d       = lfsr_q;
    lane_d       = lane_q;
    hist0_d      = hist0_q;
    hist1_d      = hist1_q;
    note_valid_d = 1'b0;
    note_cnt_d   = note_cnt_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // The LFSR is deliberately left running state so songs differ.
        if (start) begin
          state_d    = ST_PLAY;
          beat_cnt_d = '0;
          note_cnt_d = 7'd0;
        end
      end

      ST_PLAY, ST_PAUSE: begin
        if (pause) begin
          // Freeze everything, including on the terminal-count cycle.
          state_d = ST_PAUSE;
        end else begin
          // The edge that sees pause low already counts, so a pause of
          // N sampled cycles delays the beat by exactly N clocks.
          state_d = ST_PLAY;
          if (beat_end) begin
            beat_cnt_d   = '0;
            lfsr_d       = lfsr_step;
            lane_d       = issue_lane;
            hist1_d      = hist0_q;
            hist0_d      = issue_lane;
            note_valid_d = 1'b1;
            note_cnt_d   = note_cnt_q + 7'd1;
            if (note_cnt_q == LAST_NOTE) begin
              state_d = ST_DONE;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Status flags follow the next state so they line up with the last pulse.
    busy_d = (state_d == ST_PLAY) || (state_d == ST_PAUSE);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      beat_cnt_q   <= '0;
      lfsr_q       <= SEED_EFF;
      lane_q       <= 2'd0;
      hist0_q      <= 2'd0;
      hist1_q      <= 2'd0;
      note_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      note_cnt_q   <= 7'd0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      lfsr_q       <= lfsr_d;
      lane_q       <= lane_d;
      hist0_q      <= hist0_d;
      hist1_q      <= hist1_d;
      note_valid_q <= note_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      note_cnt_q   <= note_cnt_d;
    end
  end

  assign lane       = lane_q;
  assign note_valid = note_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign note_cnt   = note_cnt_q;

endmodule
